// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with internal baud divider, TX FIFO and configurable frame format
module uart_tx_fifo #(
    parameter int CLK_DIV    = 434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
    state_t state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] shift;
    logic [DW-1:0] baud;
    logic [BW-1:0] bit_cnt;
    logic par_bit, push, pop, bit_end, last_stop;
    always_comb begin
        tx_ready = fifo_count != (AW+1)'(FIFO_DEPTH);
        busy = state != IDLE || fifo_count != '0;
        bit_end = baud == '0;
        last_stop = state == STOP && bit_end && bit_cnt == BW'(STOP_BITS - 1);
        push = tx_valid && tx_ready;
        pop = (state == IDLE || last_stop) && fifo_count != '0;
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= tx_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // The next frame is popped at the final stop-bit boundary so frames run back to back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tx <= 1'b1;
            baud <= '0;
            bit_cnt <= '0;
            shift <= '0;
            par_bit <= 1'b0;
        end else begin
            baud <= (bit_end || state == IDLE) ? DW'(CLK_DIV - 1) : baud - DW'(1);
            if (pop) begin
                state <= START;
                tx <= 1'b0;
                shift <= mem[rd_ptr];
                par_bit <= ^mem[rd_ptr] ^ (PARITY == 1);
            end else if (state == IDLE || last_stop) begin
                state <= IDLE;
                tx <= 1'b1;
            end else if (bit_end) begin
                case (state)
                    START: begin
                        state <= DATA;
                        tx <= shift[0];
                        shift <= shift >> 1;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            state <= (PARITY != 0) ? PAR : STOP;
                            tx <= (PARITY != 0) ? par_bit : 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            tx <= shift[0];
                            shift <= shift >> 1;
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                    PAR: begin
                        state <= STOP;
                        tx <= 1'b1;
                        bit_cnt <= '0;
                    end
                    default: bit_cnt <= bit_cnt + BW'(1);
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three frame formats checked against an expected per-cycle line waveform
module tb_uart_tx_fifo;
    localparam int CD = 4;
    localparam int DEP = 4;
    localparam int DB [3] = '{8, 7, 8};
    localparam int PB [3] = '{0, 1, 2};
    localparam int SB [3] = '{1, 2, 1};
    logic clk = 1'b0;
    logic rst;
    logic [8:0] d [3];
    logic [2:0] v, rdy, txl, bsy;
    logic [2:0] cnt [3];
    int wq [3][$];
    int pend [3];
    int sent [3];
    int checks = 0, failures = 0;
    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .tx_data(d[0][7:0]), .tx_valid(v[0]), .tx_ready(rdy[0]),
        .tx(txl[0]), .busy(bsy[0]), .fifo_count(cnt[0]));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .tx_data(d[1][6:0]), .tx_valid(v[1]), .tx_ready(rdy[1]),
        .tx(txl[1]), .busy(bsy[1]), .fifo_count(cnt[1]));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .tx_data(d[2][7:0]), .tx_valid(v[2]), .tx_ready(rdy[2]),
        .tx(txl[2]), .busy(bsy[2]), .fifo_count(cnt[2]));

    task automatic chk(string tag, int i, logic [3:0] obs, logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask

    // Each line sample is bit0 = level, bit1 = first sample of a frame.
    function automatic void add_frame(int i, logic [8:0] w);
        int bits [$];
        int ones = 0;
        bits.push_back(0);
        for (int k = 0; k < DB[i]; k++) begin
            bits.push_back(int'(w[k]));
            ones += int'(w[k]);
        end
        if (PB[i] != 0) bits.push_back(PB[i] == 1 ? int'(ones % 2 == 0) : ones % 2);
        for (int k = 0; k < SB[i]; k++) bits.push_back(1);
        foreach (bits[b])
            for (int c = 0; c < CD; c++) wq[i].push_back(bits[b] | ((b == 0 && c == 0) ? 2 : 0));
        pend[i]++;
    endfunction

    task automatic tick();
        logic [2:0] acc;
        logic [8:0] w [3];
        logic r;
        r = rst;
        for (int i = 0; i < 3; i++) begin
            acc[i] = v[i] && !r && pend[i] != DEP;
            w[i] = d[i];
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            logic popped;
            int s;
            popped = 1'b0;
            s = 1;
            if (r) begin
                wq[i].delete();
                pend[i] = 0;
            end else if (wq[i].size() > 0) begin
                s = wq[i].pop_front();
                popped = 1'b1;
                if ((s & 2) != 0) pend[i]--;
            end
            if (acc[i]) add_frame(i, w[i]);
            chk("tx", i, 4'(txl[i]), 4'(s & 1));
            chk("busy", i, 4'(bsy[i]), 4'(popped || wq[i].size() > 0));
            chk("fifo_count", i, 4'(cnt[i]), 4'(pend[i]));
            chk("tx_ready", i, 4'(rdy[i]), 4'(pend[i] != DEP));
        end
    endtask

    initial begin
        v = '0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d[i] = '0;
            pend[i] = 0;
            sent[i] = 0;
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();
        // 0xA5 on 8N1, 0x03 on 7O2, 0x07 on 8E1
        d[0] = 9'h0A5;
        d[1] = 9'h003;
        d[2] = 9'h007;
        v = 3'b111;
        tick();
        v = '0;
        repeat (50) tick();
        d[2] = 9'h003;
        v = 3'b100;
        tick();
        v = '0;
        repeat (50) tick();
        // reset in the middle of frames with words still queued
        d[0] = 9'h13C;
        d[1] = 9'h055;
        d[2] = 9'h0F0;
        v = 3'b111;
        repeat (2) tick();
        v = '0;
        repeat (10) tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        // six words back to back into a four-deep FIFO, held while stalled
        for (int t = 0; t < 400 && (sent[0] < 6 || sent[1] < 6 || sent[2] < 6); t++) begin
            logic [2:0] ok;
            for (int i = 0; i < 3; i++) begin
                v[i] = sent[i] < 6;
                d[i] = 9'(8'h30 + sent[i] * 17 + i);
                ok[i] = v[i] && pend[i] != DEP;
            end
            tick();
            for (int i = 0; i < 3; i++) if (ok[i]) sent[i]++;
        end
        v = '0;
        for (int i = 0; i < 3; i++) chk("sent", i, 4'(sent[i]), 4'd6);
        for (int t = 0; t < 1000 && (wq[0].size() + wq[1].size() + wq[2].size()) > 0; t++) tick();
        repeat (3) tick();
        // push on the same edge as a pop with two words queued
        for (int k = 0; k < 3; k++) begin
            d[0] = 9'(8'h61 + k);
            v[0] = 1'b1;
            tick();
        end
        v[0] = 1'b0;
        for (int t = 0; t < 100 && !(wq[0].size() > 0 && (wq[0][0] & 2) != 0); t++) tick();
        chk("pp_before", 0, 4'(cnt[0]), 4'd2);
        d[0] = 9'h0C3;
        v[0] = 1'b1;
        tick();
        v[0] = 1'b0;
        chk("pp_after", 0, 4'(cnt[0]), 4'd2);
        // randomized traffic
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < 3; i++) begin
                v[i] = $urandom_range(0, 2) == 0;
                d[i] = 9'($urandom);
            end
            tick();
        end
        v = '0;
        for (int t = 0; t < 1000 && (wq[0].size() + wq[1].size() + wq[2].size()) > 0; t++) tick();
        repeat (3) tick();
        for (int i = 0; i < 3; i++) chk("drained", i, 4'(wq[i].size()), 4'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
